// File: rtl/div16u8_seq_if.sv
// Handshake bundle for the iterative 2W/W unsigned divider.
// The producer/consumer side uses master; the divider uses slave.
interface div16u8_seq_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/div16u8_seq.sv
// Radix-2 restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Unrepresentable results (divide by zero, quotient overflow) finish one cycle after accept.
module div16u8_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    div16u8_seq_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_div;
    logic          r_pend_dz, r_pend_ov;
    logic [W-1:0]  r_quot, r_remo;
    logic          r_dz, r_ov;

    logic          w_accept, w_last, w_flagged, w_ge;
    logic [W:0]    w_t;
    logic [W-1:0]  w_diff, w_rem_nxt, w_q_nxt;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;
    assign bus.div_zero  = r_dz;
    assign bus.overflow  = r_ov;

    assign w_accept  = bus.in_valid & (r_state == S_IDLE);
    assign w_last    = (r_cnt == CW'(W - 1));
    assign w_flagged = r_pend_dz | r_pend_ov;

    // The partial remainder stays below the divisor, so T - divisor always fits in W bits.
    assign w_t       = {r_rem, r_q[W-1]};
    assign w_ge      = (w_t >= {1'b0, r_div});
    assign w_diff    = w_t[W-1:0] - r_div;
    assign w_rem_nxt = w_ge ? w_diff : w_t[W-1:0];
    assign w_q_nxt   = {r_q[W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_flagged || w_last) w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_div     <= '0;
            r_pend_dz <= 1'b0;
            r_pend_ov <= 1'b0;
            r_quot    <= '0;
            r_remo    <= '0;
            r_dz      <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div     <= bus.divisor;
                        r_rem     <= bus.dividend[2*W-1:W];
                        r_q       <= bus.dividend[W-1:0];
                        r_cnt     <= '0;
                        r_pend_dz <= (bus.divisor == '0);
                        r_pend_ov <= (bus.divisor != '0) && (bus.dividend[2*W-1:W] >= bus.divisor);
                    end
                end
                S_RUN: begin
                    // Flagged operands spend one RUN cycle so both flag kinds report after E1.
                    if (w_flagged) begin
                        r_quot <= '1;
                        r_remo <= r_q;
                        r_dz   <= r_pend_dz;
                        r_ov   <= r_pend_ov;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_q   <= w_q_nxt;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quot <= w_q_nxt;
                            r_remo <= w_rem_nxt;
                            r_dz   <= 1'b0;
                            r_ov   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div16u8_seq.sv
// Directed and randomized checks of div16u8_seq against hand values and a behavioural model.
module tb_div16u8_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    div16u8_seq_if #(.W(8)) bus ();

    div16u8_seq #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for the result, hold it for `stall` cycles, then take it.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, input int stall,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov, output int lat, output int rdy_hi);
        int n;
        @(negedge clk);
        bus.dividend  = dd;
        bus.divisor   = dv;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = ~dd;
        bus.divisor  = ~dv;
        lat = 0;
        rdy_hi = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.in_ready) rdy_hi++;
        end while (!bus.out_valid && lat < 40);
        if (!bus.out_valid) chk("done_timeout", 32'(bus.out_valid), 32'd1);
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_zero;
        ov = bus.overflow;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_res", {14'd0, bus.div_zero, bus.overflow, bus.quotient, bus.remainder},
                {14'd0, dz, ov, q, r});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        if (stall > 0) chk("post_xfer_rdy", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    endtask

    task automatic xfer();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] q, r, eq, er;
        logic       dz, ov, edz, eov;
        logic [15:0] dd;
        logic [7:0]  dv;
        int lat, rdy_hi, n;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        vecs[0] = '{16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8};
        vecs[1] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
        vecs[2] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8};
        vecs[3] = '{16'hABCD, 8'h00, 8'hFF, 8'hCD, 1'b1, 1'b0, 1};
        vecs[4] = '{16'h0500, 8'h05, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        vecs[5] = '{16'h04FF, 8'h05, 8'hFF, 8'h04, 1'b0, 1'b0, 8};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy_vld", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        chk("rst_res", {14'd0, bus.div_zero, bus.overflow, bus.quotient, bus.remainder}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].dd, vecs[i].dv, (i == 0) ? 5 : 0, q, r, dz, ov, lat, rdy_hi);
            chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
            chk($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("v%0d_flags", i), {30'd0, dz, ov}, {30'd0, vecs[i].dz, vecs[i].ov});
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_rdy_busy", i), 32'(rdy_hi), 32'd0);
        end

        // New operands offered throughout RUN and DONE must wait for IDLE.
        @(negedge clk);
        bus.dividend = 16'h1234;
        bus.divisor  = 8'h56;
        bus.in_valid = 1'b1;
        chk("busy_idle_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.dividend = 16'h04FF;
        bus.divisor  = 8'h05;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("busy_a_vld", 32'(bus.out_valid), 32'd1);
        chk("busy_a_res", {16'd0, bus.quotient, bus.remainder}, 32'h3610);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("busy_a_hold", {15'd0, bus.out_valid, bus.quotient, bus.remainder}, 32'h13610);
        end
        xfer();
        @(negedge clk);
        chk("busy_b_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("busy_b_vld", 32'(bus.out_valid), 32'd1);
        chk("busy_b_res", {14'd0, bus.div_zero, bus.overflow, bus.quotient, bus.remainder}, 32'hFF04);
        xfer();

        // Reset four iterations into a run discards it entirely.
        @(negedge clk);
        bus.dividend = 16'h1234;
        bus.divisor  = 8'h56;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_rdy_vld", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        chk("mid_rst_res", {14'd0, bus.div_zero, bus.overflow, bus.quotient, bus.remainder}, 32'd0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("mid_rst_no_result", 32'(n), 32'd0);
        run_op(16'h00FF, 8'h10, 0, q, r, dz, ov, lat, rdy_hi);
        chk("post_rst_res", {14'd0, dz, ov, q, r}, 32'h0F0F);
        chk("post_rst_lat", 32'(lat), 32'd8);

        // Random operands against a behavioural divide model.
        for (int k = 0; k < 2000; k++) begin
            dv = 8'($urandom_range(0, 255));
            if (k % 2 == 0 && dv != 0)
                dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom_range(0, 255))};
            else
                dd = 16'($urandom_range(0, 65535));
            if (dv == 0) begin
                eq = 8'hFF; er = dd[7:0]; edz = 1'b1; eov = 1'b0;
            end else if (dd[15:8] >= dv) begin
                eq = 8'hFF; er = dd[7:0]; edz = 1'b0; eov = 1'b1;
            end else begin
                eq = 8'(dd / dv); er = 8'(dd % dv); edz = 1'b0; eov = 1'b0;
            end
            run_op(dd, dv, int'($urandom_range(0, 2)), q, r, dz, ov, lat, rdy_hi);
            chk("rnd_res", {14'd0, dz, ov, q, r}, {14'd0, edz, eov, eq, er});
            chk("rnd_lat", 32'(lat), (edz | eov) ? 32'd1 : 32'd8);
            if (!edz && !eov) begin
                chk("rnd_inv", 32'(q) * 32'(dv) + 32'(r), 32'(dd));
                chk("rnd_r_lt_d", 32'(r < dv), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
